// File: rtl/polar_pkg.sv
// Shared polar-code types and helpers used by the encoder and decoder datapaths.
package polar_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    DONE = 2'd2
  } enc_state_t;

  localparam int unsigned MAX_N = 64;
  localparam int unsigned MAX_W = $clog2(MAX_N);
  localparam logic [7:0]  DEFAULT_FROZEN_8 = 8'b0001_0111;

  function automatic int unsigned popcount(input logic [MAX_N-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < MAX_N; i++) begin
      c = c + 32'(v[MAX_W'(i)]);
    end
    return c;
  endfunction

  // Places info bits, lowest first, into the non-frozen positions of an n-bit u.
  function automatic logic [MAX_N-1:0] info_scatter(input logic [MAX_N-1:0] info,
                                                    input logic [MAX_N-1:0] mask,
                                                    input int unsigned      n);
    logic [MAX_N-1:0] u;
    int unsigned      k;
    u = '0;
    k = 0;
    for (int i = 0; i < MAX_N; i++) begin
      if ((32'(i) < n) && !mask[MAX_W'(i)]) begin
        u[MAX_W'(i)] = info[MAX_W'(k)];
        k = k + 1;
      end
    end
    return u;
  endfunction

endpackage

// File: rtl/polar_butterfly_stage.sv
// One GF(2) butterfly stage of x = u * F^(xor n); the stage index selects the pair stride.
module polar_butterfly_stage
  import polar_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]                   u_in,
  input  logic [$clog2($clog2(N))+1-1:0] stage,
  output logic [N-1:0]                   u_out
);

  localparam int unsigned LOGN = $clog2(N);
  localparam int unsigned SW   = $clog2(LOGN) + 1;

  logic [LOGN-1:0][N-1:0] w_st;

  // Every stage is built in parallel; lower half of each pair absorbs its partner.
  for (genvar gs = 0; gs < LOGN; gs++) begin : g_stage
    for (genvar gi = 0; gi < N; gi++) begin : g_bit
      if (((gi >> gs) & 1) == 1) begin : g_pass
        assign w_st[gs][gi] = u_in[gi];
      end else begin : g_xor
        assign w_st[gs][gi] = u_in[gi] ^ u_in[gi + (1 << gs)];
      end
    end
  end

  always_comb begin
    u_out = u_in;
    for (int s = 0; s < LOGN; s++) begin
      if (stage == SW'(s)) begin
        u_out = w_st[s];
      end
    end
  end

endmodule

// File: rtl/polar_encoder.sv
// Sequential polar encoder: scatters info bits into u, runs one butterfly stage per clock,
// then presents the N-bit codeword on a valid/ready output.
module polar_encoder
  import polar_pkg::*;
#(
  parameter int unsigned   N           = 8,
  parameter int unsigned   K           = 4,
  parameter logic [N-1:0]  FROZEN_MASK = N'(DEFAULT_FROZEN_8)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [K-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         busy
);

  localparam int unsigned LOGN = $clog2(N);
  localparam int unsigned SW   = $clog2(LOGN) + 1;

  if ((N < 2) || (N > MAX_N) || ((N & (N - 1)) != 0)) begin : g_bad_n
    $error("polar_encoder: N must be a power of 2 in [2, %0d]", MAX_N);
  end
  if (K != N - popcount(MAX_N'(FROZEN_MASK))) begin : g_bad_k
    $error("polar_encoder: K must equal N - popcount(FROZEN_MASK)");
  end

  enc_state_t    r_state;
  logic [N-1:0]  r_u;
  logic [SW-1:0] r_stage;
  logic          r_in_ready;
  logic          r_out_valid;
  logic [N-1:0]  r_out_data;
  logic          r_busy;

  logic [N-1:0]  w_scatter;
  logic [N-1:0]  w_u_next;

  assign w_scatter = N'(info_scatter(MAX_N'(in_data), MAX_N'(FROZEN_MASK), N));

  polar_butterfly_stage #(
    .N (N)
  ) u_stage (
    .u_in  (r_u),
    .stage (r_stage),
    .u_out (w_u_next)
  );

  // FSM, datapath registers and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_u         <= '0;
      r_stage     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_u        <= w_scatter;
            r_stage    <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ENC;
          end
        end
        ENC: begin
          r_u     <= w_u_next;
          r_stage <= r_stage + SW'(1);
          if (r_stage == SW'(LOGN - 1)) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_u_next;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;

endmodule

// File: tb/tb_polar_encoder.sv
// Directed bench for polar_encoder (N=8, K=4, frozen {0,1,2,4}) with a superset-XOR reference.
module tb_polar_encoder;

  localparam logic [7:0] TB_MASK = 8'b0001_0111;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;

  int n_total;
  int n_bad;
  int cyc;
  int acc_q[$];
  logic [7:0] out_q[$];

  polar_encoder #(
    .N           (8),
    .K           (4),
    .FROZEN_MASK (TB_MASK)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake monitor: records accept cycles and delivered codewords.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && in_valid && in_ready) acc_q.push_back(cyc);
    if (rst_n && out_valid && out_ready) out_q.push_back(out_data);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] ref_encode(input logic [3:0] info);
    logic [7:0] m;
    logic [7:0] u;
    logic [7:0] x;
    int k;
    m = TB_MASK;
    u = '0;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      if (!m[i]) begin
        u[i] = info[k];
        k++;
      end
    end
    for (int j = 0; j < 8; j++) begin
      x[j] = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if ((i & j) == j) x[j] = x[j] ^ u[i];
      end
    end
    return x;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] info);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", in_ready, 1);
    in_valid = 1'b1;
    in_data  = info;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_word(input string tag, input logic [3:0] info, input logic [7:0] exp,
                          output logic [7:0] got);
    int lat;
    send(info);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_in_ready_lo"}, in_ready, 0);
    wait_valid(lat);
    chk({tag, "_latency"}, lat, 3);
    got = out_data;
    chk({tag, "_data"}, out_data, exp);
    chk({tag, "_model"}, out_data, ref_encode(info));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, out_valid, 0);
    chk({tag, "_in_ready_back"}, in_ready, 1);
    chk({tag, "_busy_drop"}, busy, 0);
  endtask

  initial begin
    logic [7:0] r1, r2, r4, r8, r0, r15;
    int lat;
    int n;
    n_total   = 0;
    n_bad     = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    repeat (2) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", in_ready, 1);

    // Single-bit info words, zero word, all-ones word
    run_word("w0001", 4'b0001, 8'h0F, r1);
    run_word("w0010", 4'b0010, 8'h33, r2);
    run_word("w0100", 4'b0100, 8'h55, r4);
    run_word("w1000", 4'b1000, 8'hFF, r8);
    run_word("w0000", 4'b0000, 8'h00, r0);
    run_word("w1111", 4'b1111, 8'h96, r15);
    chk("linearity", r1 ^ r2 ^ r4 ^ r8, r15);

    // Backpressure: codeword held, second word refused until the output handshake
    send(4'b1111);
    wait_valid(lat);
    chk("bp_latency", lat, 3);
    in_valid = 1'b1;
    in_data  = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_valid_held", out_valid, 1);
      chk("bp_data_held", out_data, 8'h96);
      chk("bp_in_ready_lo", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_valid_drop", out_valid, 0);
    chk("bp_in_ready_back", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_second_accept", busy, 1);
    wait_valid(lat);
    chk("bp2_latency", lat, 3);
    chk("bp2_data", out_data, 8'h0F);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Back-to-back with in_valid and out_ready held high
    acc_q.delete();
    out_q.delete();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 4'b0001;
    tick();
    in_data = 4'b1000;
    n = 0;
    while (acc_q.size() < 2 && n < 20) begin
      tick();
      n++;
    end
    in_valid = 1'b0;
    n = 0;
    while (out_q.size() < 2 && n < 30) begin
      tick();
      n++;
    end
    out_ready = 1'b0;
    chk("b2b_n_accepts", acc_q.size(), 2);
    chk("b2b_n_outputs", out_q.size(), 2);
    if (acc_q.size() >= 2) chk("b2b_interval", acc_q[1] - acc_q[0], 5);
    if (out_q.size() >= 2) begin
      chk("b2b_first", out_q[0], 8'h0F);
      chk("b2b_second", out_q[1], 8'hFF);
    end

    // Reset during ENC stage 1 discards the word
    send(4'b0001);
    tick();
    chk("abort_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("abort_in_ready", in_ready, 1);
    repeat (4) tick();
    chk("abort_no_output", out_valid, 0);
    run_word("post_abort", 4'b0100, 8'h55, r4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
